seg_display_scanner: RTL and testbench

Time-multiplexed 7-segment driver downstream of the traffic light controller top. Consumes the two-digit BCD countdowns and light states for directions A and B, snapshots them once per scan frame, and scans four digits onto one shared segment bus. Adds leading-zero blanking, a green-direction decimal point, and blinking of the green direction's digits near timeout.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/seg_display_scanner_bcd_to_seg.sv | 33 +++
 rtl/seg_display_scanner.sv | 122 ++++++++++++
 tb/tb_seg_display_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-light display path: segment
// patterns {g,f,e,d,c,b,a}, scan digit indices and the per-frame snapshot record.
package traffic_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] IDX_A_L = 2'd0;
  localparam logic [1:0] IDX_A_H = 2'd1;
  localparam logic [1:0] IDX_B_L = 2'd2;
  localparam logic [1:0] IDX_B_H = 2'd3;

  typedef struct packed {
    logic [3:0] a_l;
    logic [3:0] a_h;
    logic [3:0] b_l;
    logic [3:0] b_h;
    logic       a_light;
    logic       b_light;
  } snap_t;

endpackage

// File: rtl/seg_display_scanner_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder with a forced-blank input; values
// above 9 render as a dash.
module bcd_to_seg
  import traffic_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed 7-segment scanner for the two traffic countdowns, with
// per-frame input snapshot, leading-zero blanking, green decimal point and blink.
module seg_display_scanner
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_DIV    = 8,
  parameter int BLINK_THRESH = 5
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_Light,
  input  logic       B_Light,
  output logic [6:0] Seg,
  output logic [3:0] Dig,
  output logic       Dp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);
  localparam logic [3:0]       THRESH   = 4'(BLINK_THRESH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             phase_q, phase_d;
  snap_t            snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;
  logic             dp_q, dp_d;

  logic       div_wrap, frame_wrap;
  logic       blink_a, blink_b;
  logic [3:0] cur_bcd;
  logic       cur_blank;

  always_comb begin
    div_wrap   = (div_q == DIV_LAST);
    frame_wrap = div_wrap && (idx_q == IDX_B_H);
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    idx_d      = div_wrap ? idx_q + 2'd1 : idx_q;

    snap_d  = snap_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    // Inputs are only taken at frame boundaries so a frame never mixes old and new values.
    if (frame_wrap) begin
      snap_d = '{a_l: A_Time_L, a_h: A_Time_H, b_l: B_Time_L, b_h: B_Time_H,
                 a_light: A_Light, b_light: B_Light};
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    blink_a = snap_q.a_light && (snap_q.a_h == 4'd0) && (snap_q.a_l < THRESH) && !phase_q;
    blink_b = snap_q.b_light && (snap_q.b_h == 4'd0) && (snap_q.b_l < THRESH) && !phase_q;

    cur_bcd   = snap_q.a_l;
    cur_blank = blink_a;
    case (idx_q)
      IDX_A_H: begin
        cur_bcd   = snap_q.a_h;
        cur_blank = blink_a || (snap_q.a_h == 4'd0);
      end
      IDX_B_L: begin
        cur_bcd   = snap_q.b_l;
        cur_blank = blink_b;
      end
      IDX_B_H: begin
        cur_bcd   = snap_q.b_h;
        cur_blank = blink_b || (snap_q.b_h == 4'd0);
      end
      default: ;
    endcase

    dig_d = 4'b0001 << idx_q;
    dp_d  = ((idx_q == IDX_A_L) && snap_q.a_light) || ((idx_q == IDX_B_L) && snap_q.b_light);
  end

  bcd_to_seg u_dec (
    .bcd_i   (cur_bcd),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!R) begin
      div_q   <= '0;
      idx_q   <= IDX_A_L;
      frm_q   <= '0;
      phase_q <= 1'b1;
      snap_q  <= '0;
      seg_q   <= SEG_BLANK;
      dig_q   <= 4'b0000;
      dp_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
    end
  end

  assign Seg = seg_q;
  assign Dig = dig_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench: a frame/slot arithmetic model predicts every output cycle,
// plus directed literal checks of the display scenarios.
module tb_seg_display_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_DIV    = 2;
  localparam int BLINK_THRESH = 5;
  localparam int FRAME        = 4 * SCAN_DIV;

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       CLK = 1'b0;
  logic       R   = 1'b0;
  logic [3:0] A_Time_L = '0, A_Time_H = '0, B_Time_L = '0, B_Time_H = '0;
  logic       A_Light = 1'b0, B_Light = 1'b0;
  logic [6:0] Seg;
  logic [3:0] Dig;
  logic       Dp;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_DIV    (BLINK_DIV),
    .BLINK_THRESH (BLINK_THRESH)
  ) dut (
    .CLK      (CLK),
    .R        (R),
    .A_Time_L (A_Time_L),
    .A_Time_H (A_Time_H),
    .B_Time_L (B_Time_L),
    .B_Time_H (B_Time_H),
    .A_Light  (A_Light),
    .B_Light  (B_Light),
    .Seg      (Seg),
    .Dig      (Dig),
    .Dp       (Dp)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output at edge k after reset comes from slot k/SCAN_DIV,
  // frame k/FRAME, and the inputs seen at the last edge of the previous frame.
  logic [3:0] m_dig [4];
  logic       m_light [2];
  int         edges = 0;
  bit         model_valid = 0;
  logic [6:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_dp;
  int         kk, fr, slot, lo, hi, v;
  bit         ph, light, high, blink;

  always @(posedge CLK) begin
    if (!R) begin
      edges = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_light[0] = 1'b0;
      m_light[1] = 1'b0;
      exp_seg = 7'h00;
      exp_dig = 4'h0;
      exp_dp  = 1'b0;
    end else begin
      kk    = edges;
      fr    = kk / FRAME;
      slot  = (kk / SCAN_DIV) % 4;
      ph    = ((fr / BLINK_DIV) % 2) == 0;
      high  = (slot % 2) == 1;
      lo    = int'(m_dig[slot & 2]);
      hi    = int'(m_dig[slot | 1]);
      v     = int'(m_dig[slot]);
      light = m_light[slot / 2];
      blink = light && hi == 0 && lo < BLINK_THRESH && !ph;
      if (blink || (high && v == 0)) exp_seg = 7'h00;
      else if (v > 9)                exp_seg = 7'h40;
      else                           exp_seg = PAT[v];
      exp_dig = 4'(1 << slot);
      exp_dp  = light && !high;
      if (kk % FRAME == FRAME - 1) begin
        m_dig[0] = A_Time_L; m_dig[1] = A_Time_H;
        m_dig[2] = B_Time_L; m_dig[3] = B_Time_H;
        m_light[0] = A_Light; m_light[1] = B_Light;
      end
      edges++;
    end
    model_valid = 1;
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      check("dig", Dig, exp_dig);
      check("seg", Seg, exp_seg);
      check("dp",  Dp,  exp_dp);
    end
  end

  task automatic set_in(input logic [3:0] ah, al, bh, bl, input logic la, lb);
    A_Time_H = ah; A_Time_L = al; B_Time_H = bh; B_Time_L = bl;
    A_Light = la;  B_Light = lb;
  endtask

  task automatic wait_slot(input logic [3:0] target, input string name);
    int n = 0;
    bit ok;
    do begin
      @(negedge CLK);
      n++;
    end while (Dig !== target && n < 64);
    ok = (Dig === target);
    check({name, "_reach"}, 32'(ok), 32'd1);
  endtask

  int vis_a, blank_a, vis_b, blank_b;

  initial begin
    // Reset with A=25, B=07, A green
    set_in(4'd2, 4'd5, 4'd0, 4'd7, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      check("rst_dig", Dig, 4'b0000);
      check("rst_seg", Seg, 7'h00);
      check("rst_dp",  Dp,  1'b0);
    end
    R = 1'b1;
    @(negedge CLK);
    check("first_dig", Dig, 4'b0001);
    check("first_seg", Seg, 7'h3F);
    check("first_dp",  Dp,  1'b0);
    repeat (4) @(negedge CLK);
    check("f0_ah_dig", Dig, 4'b0010);
    check("f0_ah_seg", Seg, 7'h00);
    wait_slot(4'b0001, "s1_al"); check("s1_al_seg", Seg, 7'h6D); check("s1_al_dp", Dp, 1'b1);
    wait_slot(4'b0010, "s1_ah"); check("s1_ah_seg", Seg, 7'h5B); check("s1_ah_dp", Dp, 1'b0);
    wait_slot(4'b0100, "s1_bl"); check("s1_bl_seg", Seg, 7'h07); check("s1_bl_dp", Dp, 1'b0);
    wait_slot(4'b1000, "s1_bh"); check("s1_bh_seg", Seg, 7'h00);

    // A=03 green blinks, B=07 steady
    set_in(4'd0, 4'd3, 4'd0, 4'd7, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    vis_a = 0; blank_a = 0;
    for (int f = 0; f < 8; f++) begin
      wait_slot(4'b0001, "blk_al");
      if (Seg === 7'h4F) vis_a++;
      else if (Seg === 7'h00) blank_a++;
      check("blk_al_dp", Dp, 1'b1);
      wait_slot(4'b0100, "blk_bl");
      check("blk_bl_seg", Seg, 7'h07);
    end
    check("blk_vis", vis_a, 4);
    check("blk_blank", blank_a, 4);

    // A=05 and A=10 never blink
    set_in(4'd0, 4'd5, 4'd0, 4'd1, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    for (int f = 0; f < 4; f++) begin
      wait_slot(4'b0001, "nb5"); check("nb5_seg", Seg, 7'h6D);
    end
    set_in(4'd1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    for (int f = 0; f < 4; f++) begin
      wait_slot(4'b0001, "nb10_l"); check("nb10_l_seg", Seg, 7'h3F);
      wait_slot(4'b0010, "nb10_h"); check("nb10_h_seg", Seg, 7'h06);
    end

    // Out-of-range low digit shows a dash
    set_in(4'd0, 4'hC, 4'd0, 4'd1, 1'b0, 1'b0);
    repeat (40) @(negedge CLK);
    wait_slot(4'b0001, "dash"); check("dash_seg", Seg, 7'h40);

    // Mid-frame change 12 -> 34 is held off until the next frame
    set_in(4'd1, 4'd2, 4'd1, 4'd2, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    wait_slot(4'b0010, "mid_ah");
    set_in(4'd3, 4'd4, 4'd3, 4'd4, 1'b1, 1'b0);
    check("mid_ah_seg", Seg, 7'h06);
    wait_slot(4'b0100, "mid_bl"); check("mid_bl_seg", Seg, 7'h5B);
    wait_slot(4'b1000, "mid_bh"); check("mid_bh_seg", Seg, 7'h06);
    wait_slot(4'b0001, "new_al"); check("new_al_seg", Seg, 7'h66);
    wait_slot(4'b0010, "new_ah"); check("new_ah_seg", Seg, 7'h4F);

    // Both green: A=02, B=01
    set_in(4'd0, 4'd2, 4'd0, 4'd1, 1'b1, 1'b1);
    repeat (40) @(negedge CLK);
    vis_a = 0; blank_a = 0; vis_b = 0; blank_b = 0;
    for (int f = 0; f < 8; f++) begin
      wait_slot(4'b0001, "bg_al");
      check("bg_al_dp", Dp, 1'b1);
      if (Seg === 7'h5B) vis_a++; else if (Seg === 7'h00) blank_a++;
      wait_slot(4'b0100, "bg_bl");
      check("bg_bl_dp", Dp, 1'b1);
      if (Seg === 7'h06) vis_b++; else if (Seg === 7'h00) blank_b++;
    end
    check("bg_a_vis", vis_a, 4);
    check("bg_a_blank", blank_a, 4);
    check("bg_b_vis", vis_b, 4);
    check("bg_b_blank", blank_b, 4);

    // Randomized inputs and occasional mid-frame resets, checked by the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 299) == 0) begin
        R = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
        R = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        set_in(($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'd0,
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'd0,
               4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
